// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Post-commit store buffer sitting between the MEM stage and data memory.
// Stores are queued in FIFO order and drained one at a time to memory; loads
// may optionally be forwarded from the buffered stores.
//
// Configuration macro:
//   STORE_FWD_EN  - when defined, loads are forwarded byte-lane by byte-lane
//                   from the youngest matching entries. When undefined, any
//                   load stalls while the buffer is non-empty.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   st_valid/st_addr/st_byteen/st_data   store request from MEM
//   st_ready                     buffer can take a store this cycle
//   ld_valid/ld_addr/ld_byteen   load lookup from MEM
//   ld_hit/ld_data/ld_stall      combinational lookup result
//   mem_req/mem_addr/mem_byteen/mem_wdata  head entry presented to memory
//   mem_ack                      memory accepts the head write
//   count                        number of occupied entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [3:0]               st_byteen,
    input  logic [31:0]              st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    input  logic [3:0]               ld_byteen,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     ld_stall,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [3:0]               mem_byteen,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  byteen;
        logic [31:0] data;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          new_entry_d;
    entry_t          head;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    // Status depends on registered occupancy only, so a full buffer refuses a
    // store even in a cycle where the head is being drained.
    assign st_ready = (count_q != CW'(DEPTH));
    assign mem_req  = (count_q != '0);

    // A zero-byte-enable store is accepted but never occupies an entry.
    assign push = st_valid && st_ready && (st_byteen != 4'b0);
    assign pop  = mem_req && mem_ack;

    assign new_entry_d = '{addr: st_addr[31:2], byteen: st_byteen, data: st_data};

    assign head       = entry_q[rd_ptr_q];
    assign mem_addr   = {head.addr, 2'b00};
    assign mem_byteen = head.byteen;
    assign mem_wdata  = head.data;
    assign count      = count_q;

    // Pointers are PW bits wide and DEPTH is a power of two, so the
    // increment wraps from DEPTH-1 to 0 on its own.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry array has no reset; its contents are meaningless while
    // count is 0, and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= new_entry_d;
    end

`ifdef STORE_FWD_EN
    logic [3:0]    fwd_found;
    logic [31:0]   fwd_data;
    logic [PW-1:0] fwd_idx;
    logic          unused_bits;

    // Walk the occupied entries oldest to youngest; a younger match simply
    // overwrites the lane an older one supplied.
    always_comb begin
        fwd_found = '0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (entry_q[fwd_idx].addr == ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (entry_q[fwd_idx].byteen[b] && ld_byteen[b]) begin
                        fwd_found[b]       = 1'b1;
                        fwd_data[8*b +: 8] = entry_q[fwd_idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ld_hit      = ld_valid && (ld_byteen != 4'b0) && (fwd_found == ld_byteen);
    assign ld_stall    = ld_valid && (fwd_found != 4'b0) && (fwd_found != ld_byteen);
    assign ld_data     = ld_hit ? fwd_data : 32'h0;
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
`else
    logic unused_bits;

    // Without forwarding any load must wait until the buffer has drained.
    assign ld_hit      = 1'b0;
    assign ld_data     = 32'h0;
    assign ld_stall    = ld_valid && (count_q != '0);
    assign unused_bits = ^{st_addr[1:0], ld_addr, ld_byteen};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer. A queue-based reference model tracks
// the buffer contents; accepted stores push the expected memory write into a
// scoreboard, and a monitor pops and compares whenever memory acknowledges a
// write. Directed scenarios are followed by a randomized phase.
// Honours STORE_FWD_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic          clk;
    logic          reset_n;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [3:0]    st_byteen;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic [3:0]    ld_byteen;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          ld_stall;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_byteen;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_err    = 0;

    wr_t model_q[$];   // reference contents of the buffer, oldest first
    wr_t exp_q[$];     // scoreboard of memory writes still to be observed

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteen  (st_byteen),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_byteen  (ld_byteen),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_stall   (ld_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Load lookup computed from the rules: per requested lane, the youngest
    // buffered store to the same word with that lane enabled.
    function automatic void fwd_ref(input logic valid, input logic [31:0] a,
                                    input logic [3:0] need, output logic hit,
                                    output logic [31:0] data, output logic stall);
        logic [3:0] found;
        found = 4'b0;
        data  = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (need[b]) begin
                for (int i = model_q.size() - 1; i >= 0; i--) begin
                    if (model_q[i].addr == {a[31:2], 2'b00} && model_q[i].be[b]) begin
                        found[b]       = 1'b1;
                        data[8*b +: 8] = model_q[i].data[8*b +: 8];
                        break;
                    end
                end
            end
        end
`ifdef STORE_FWD_EN
        hit   = valid && (need != 4'b0) && (found == need);
        stall = valid && (found != 4'b0) && (found != need);
        if (!hit) data = 32'h0;
`else
        hit   = 1'b0;
        data  = 32'h0;
        stall = valid && (model_q.size() != 0);
`endif
    endfunction

    // Reference model: updates contents at each edge from the inputs that
    // were presented during the preceding cycle.
    int  m_sz;
    wr_t m_new;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            m_sz = model_q.size();
            if (mem_ack && m_sz != 0) void'(model_q.pop_front());
            if (st_valid && m_sz != DEPTH && st_byteen != 4'b0) begin
                m_new.addr = {st_addr[31:2], 2'b00};
                m_new.be   = st_byteen;
                m_new.data = st_data;
                model_q.push_back(m_new);
                exp_q.push_back(m_new);
            end
        end
    end

    // Monitor: mid-cycle, compares status, head and load lookup, and pops
    // the scoreboard for each write memory accepts at the coming edge.
    logic        r_hit, r_stall;
    logic [31:0] r_data;
    wr_t         w;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("count", 32'(count), 32'(model_q.size()));
            check("st_ready", 32'(st_ready), 32'(model_q.size() != DEPTH));
            check("mem_req", 32'(mem_req), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check("head_addr", mem_addr, model_q[0].addr);
                check("head_byteen", 32'(mem_byteen), 32'(model_q[0].be));
                check("head_wdata", mem_wdata, model_q[0].data);
            end
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_req), 32'(0));
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_byteen", 32'(mem_byteen), 32'(w.be));
                    check("wr_wdata", mem_wdata, w.data);
                end
            end
            fwd_ref(ld_valid, ld_addr, ld_byteen, r_hit, r_data, r_stall);
            check("ld_hit", 32'(ld_hit), 32'(r_hit));
            check("ld_data", ld_data, r_data);
            check("ld_stall", 32'(ld_stall), 32'(r_stall));
        end
    end

    // Advance one edge; inputs change 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic done;
        done      = 1'b0;
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteen = be;
        st_data   = d;
        for (int k = 0; k < 50 && !done; k++) begin
            done = st_ready;
            step();
        end
        st_valid = 1'b0;
        check("store_accept", 32'(done), 32'(1));
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        repeat (DEPTH + 2) step();
        mem_ack = 1'b0;
        check("drained", 32'(count), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_byteen = '0;
        st_data   = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_byteen = '0;
        mem_ack   = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'(0));
        check("rst_st_ready", 32'(st_ready), 32'(1));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_ld_stall", 32'(ld_stall), 32'(0));
        #1 reset_n = 1'b1;
        step();

        // Fill to capacity, hold a fifth store, free one slot.
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(4 * i), 4'hF, $urandom);
        check("fill_count", 32'(count), 32'(4));
        check("fill_ready", 32'(st_ready), 32'(0));
        st_valid = 1'b1; st_addr = 32'h110; st_byteen = 4'hF; st_data = 32'hCAFE0005;
        step();
        check("held_count", 32'(count), 32'(4));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("pop_full_count", 32'(count), 32'(3));
        check("pop_full_ready", 32'(st_ready), 32'(1));
        step();
        st_valid = 1'b0;
        check("fifth_accept", 32'(count), 32'(4));
        drain();

        // Ordering with memory always ready.
        mem_ack = 1'b1;
        do_store(32'h200, 4'hF, 32'h11223344);
        check("ordA_addr", mem_addr, 32'h200);
        check("ordA_data", mem_wdata, 32'h11223344);
        do_store(32'h204, 4'h1, 32'h00000055);
        check("ordB_addr", mem_addr, 32'h204);
        check("ordB_data", mem_wdata, 32'h00000055);
        check("ordB_count", 32'(count), 32'(1));
        step();
        check("ord_empty", 32'(count), 32'(0));
        mem_ack = 1'b0;

        // Forwarding merge from two stores to the same word.
        do_store(32'h300, 4'h3, 32'h0000BEEF);
        do_store(32'h300, 4'h2, 32'h0000AA00);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_byteen = 4'h3;
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit", 32'(ld_hit), 32'(1));
        check("fwd_data", ld_data, 32'h0000AAEF);
        check("fwd_stall", 32'(ld_stall), 32'(0));
`else
        check("nofwd_hit", 32'(ld_hit), 32'(0));
        check("nofwd_data", ld_data, 32'h0);
        check("nofwd_stall", 32'(ld_stall), 32'(1));
`endif
        ld_valid = 1'b0;
        drain();

        // Partial overlap stalls until the entry drains.
        do_store(32'h400, 4'h1, 32'h0000007F);
        ld_valid = 1'b1; ld_addr = 32'h400; ld_byteen = 4'hF;
        #1;
        check("part_stall", 32'(ld_stall), 32'(1));
        check("part_hit", 32'(ld_hit), 32'(0));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check("part_released", 32'(ld_stall), 32'(0));
        check("part_nohit", 32'(ld_hit), 32'(0));
        ld_valid = 1'b0;

        // Reset pulse between edges while draining.
        for (int i = 0; i < 3; i++) do_store(32'h500 + 32'(4 * i), 4'hF, $urandom);
        check("pre_rst_req", 32'(mem_req), 32'(1));
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_req", 32'(mem_req), 32'(0));
        check("mid_rst_ready", 32'(st_ready), 32'(1));
        #1 reset_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_req", 32'(mem_req), 32'(0));
        end
        mem_ack = 1'b0;

        // Zero byte enables, then back-to-back push/pop across the wrap.
        do_store(32'h600, 4'hF, 32'h66666666);
        do_store(32'h604, 4'h0, 32'h77777777);
        check("zero_be_count", 32'(count), 32'(1));
        drain();
        mem_ack = 1'b1;
        st_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            st_addr = 32'h700 + 32'(4 * k); st_byteen = 4'hF; st_data = $urandom;
            step();
        end
        st_valid = 1'b0;
        check("thru_count", 32'(count), 32'(1));
        step();
        check("thru_empty", 32'(count), 32'(0));
        mem_ack = 1'b0;

        // Randomized traffic on a small address set to provoke overlaps.
        for (int k = 0; k < 400; k++) begin
            st_valid  = ($urandom_range(0, 99) < 60);
            st_addr   = 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            st_byteen = 4'($urandom_range(0, 15));
            st_data   = $urandom;
            mem_ack   = ($urandom_range(0, 99) < 45);
            ld_valid  = ($urandom_range(0, 99) < 70);
            ld_addr   = 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            ld_byteen = 4'($urandom_range(1, 15));
            step();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        drain();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; a power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port st_valid, input, 1 bit: a store from the MEM stage is presented.
REQ-005 SHALL have port st_addr, input, 32 bits: store address; bits [1:0] are ignored.
REQ-006 SHALL have port st_byteen, input, 4 bits: store byte enables, already lane-aligned.
REQ-007 SHALL have port st_data, input, 32 bits: store data, already lane-shifted.
REQ-008 SHALL have port st_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-009 SHALL have port ld_valid, input, 1 bit: a load is presented in MEM.
REQ-010 SHALL have port ld_addr, input, 32 bits: load address; bits [1:0] are ignored.
REQ-011 SHALL have port ld_byteen, input, 4 bits: the byte lanes the load needs.
REQ-012 SHALL have port ld_hit, output, 1 bit: the load is fully satisfied by the buffer.
REQ-013 SHALL have port ld_data, output, 32 bits: the forwarded load word; 0 when ld_hit=0.
REQ-014 SHALL have port ld_stall, output, 1 bit: the pipeline must hold the load.
REQ-015 SHALL have port mem_req, output, 1 bit: a write to data memory is pending.
REQ-016 SHALL have ports mem_addr (32 bits), mem_byteen (4 bits) and mem_wdata (32 bits), all outputs: the head entry; mem_addr[1:0] is driven as 0.
REQ-017 SHALL have port mem_ack, input, 1 bit: data memory accepts the head write this cycle.
REQ-018 SHALL have port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-019 SHALL be a FIFO of {addr[31:2], byteen, data} entries with a wrap-around read pointer, write pointer and registered count.
REQ-020 SHALL drive st_ready = (count != DEPTH), computed from registered state only.
REQ-021 SHALL push an entry at the clock edge when st_valid && st_ready && st_byteen != 0.
REQ-022 SHALL accept a store with st_byteen == 0 and discard it without pushing.
REQ-023 SHALL drive mem_req = (count != 0), with mem_addr, mem_byteen and mem_wdata taken from the head entry.
REQ-024 SHALL pop the head at the edge where mem_req && mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-025 SHALL keep the mem_* outputs stable while mem_req=1 and mem_ack=0.
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL refuse a store arriving when full, even if mem_ack pops in the same cycle; the store is accepted on the following cycle.
REQ-028 SHALL let both pointers wrap from DEPTH-1 to 0.
REQ-029 SHALL keep drained writes in FIFO order; no coalescing or reordering is permitted.
REQ-030 SHALL drive ld_hit, ld_data and ld_stall combinationally, with zero-cycle latency; all three are 0 when ld_valid=0.

Reset
REQ-031 SHALL, on reset_n=0 (asynchronous), immediately clear both pointers and count, drive mem_req=0, and drive st_ready=1.
REQ-032 SHALL discard the entry being drained when reset asserts mid-drain, with no write issued afterwards.
REQ-033 SHALL NOT reset the entry storage; the contents are don't-care once count=0.

Configuration
REQ-034 SHALL implement forwarding under macro STORE_FWD_EN.
- Defined: each requested lane is taken from the youngest valid entry with a matching addr[31:2] and that lane enabled.
- All requested lanes found -> ld_hit=1, ld_data = the merged lanes (unrequested lanes 0), ld_stall=0.
- Some but not all lanes found -> ld_stall=1, ld_hit=0.
- No lane found -> ld_hit=0, ld_stall=0.
REQ-035 SHALL, without STORE_FWD_EN, drive ld_stall = ld_valid && (count != 0), ld_hit=0 and ld_data=0, and omit the comparators.

Verification
REQ-036 SHALL cover fill: 4 stores to 0x100..0x10C with mem_ack=0 -> count=4, st_ready=0; a 5th store is held; mem_ack for 1 cycle -> count=3, then the 5th store is accepted.
REQ-037 SHALL cover ordering: stores A=0x200/0xF/0x11223344 then B=0x204/0x1/0x55 with mem_ack=1 -> mem sees A then B on consecutive cycles, count returns to 0.
REQ-038 SHALL cover forwarding (STORE_FWD_EN): store 0x300/0x3/0x0000BEEF, then store 0x300/0x2/0x0000AA00; load 0x300 with ld_byteen=0x3 -> ld_hit=1, ld_data=0x0000AAEF, ld_stall=0.
REQ-039 SHALL cover partial overlap: buffer holds 0x400/0x1/0x7F; load 0x400 with ld_byteen=0xF -> ld_stall=1 until the entry drains, then ld_stall=0 and ld_hit=0.
REQ-040 SHALL cover reset mid-drain: 3 entries, mem_req=1, reset_n pulsed low between edges -> count=0 and mem_req=0 immediately, with no further mem_req after release.
REQ-041 SHALL cover zero byteen and wrap: a store with st_byteen=0 leaves count unchanged; 10 push/pop pairs at full throughput -> correct data after pointer wrap.
